// File: rtl/msrh_l2_responder_if.sv
// Shared LSU/L2 channel types plus the L1D->L2 request and L2->L1D response interfaces.
// The package sits ahead of the interfaces so both can import it.
package msrh_lsu_pkg;
  localparam int PADDR_W         = 40;
  localparam int DCACHE_DATA_B_W = 16;
  localparam int DCACHE_DATA_W   = DCACHE_DATA_B_W * 8;
  localparam int L2_CMD_TAG_W    = 8;

  typedef logic [4:0] mem_cmd_t;
  localparam mem_cmd_t M_XRD = 5'b00000;
  localparam mem_cmd_t M_XWR = 5'b00001;

  typedef struct packed {
    mem_cmd_t                    cmd;
    logic [PADDR_W-1:0]          addr;
    logic [L2_CMD_TAG_W-1:0]     tag;
    logic [DCACHE_DATA_W-1:0]    data;
    logic [DCACHE_DATA_B_W-1:0]  byte_en;
  } l2_req_t;

  typedef struct packed {
    logic [L2_CMD_TAG_W-1:0]     tag;
    logic [DCACHE_DATA_W-1:0]    data;
  } l2_resp_t;
endpackage

interface l2_req_if;
  import msrh_lsu_pkg::*;
  logic    valid;
  logic    ready;
  l2_req_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

interface l2_resp_if;
  import msrh_lsu_pkg::*;
  logic     valid;
  logic     ready;
  l2_resp_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/msrh_l2_responder.sv
// L2 stand-in: in-order request queue serviced against a line-granular backing store,
// read data returned after a fixed latency with the request tag echoed.
module msrh_l2_responder
  import msrh_lsu_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int MEM_LINES = 1024,
  parameter int READ_LAT  = 3
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  l2_req_if.slave    l2_req,
  l2_resp_if.master  l2_resp
);

  // state   | meaning
  // IDLE    | pop head when queue non-empty; writes/unknown cmds retire here
  // RD_WAIT | read latency countdown, no pops
  // RESP    | response valid, held until consumer ready
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam int PTR_W      = $clog2(REQ_DEPTH);
  localparam int LINE_IDX_W = $clog2(MEM_LINES);
  localparam int BYTE_OFS_W = $clog2(DCACHE_DATA_B_W);
  localparam int CNT_W      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("REQ_DEPTH must be a power of 2 and at least 2");
  end
  if (MEM_LINES < 2 || (MEM_LINES & (MEM_LINES - 1)) != 0) begin : g_bad_lines
    $error("MEM_LINES must be a power of 2");
  end
  if (READ_LAT < 1) begin : g_bad_lat
    $error("READ_LAT must be at least 1");
  end

  l2_req_t                  fifo_q [REQ_DEPTH];
  logic [PTR_W:0]           wr_ptr_q;
  logic [PTR_W:0]           rd_ptr_q;
  logic                     empty;
  logic                     full;
  logic                     push;
  logic                     pop;

  logic [DCACHE_DATA_W-1:0] mem_q [MEM_LINES];

  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     wr_en;
  logic                     rd_capture;
  l2_resp_t                 resp_q;

  l2_req_t                  head;
  logic [LINE_IDX_W-1:0]    head_idx;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign push  = l2_req.valid && !full;

  assign head     = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign head_idx = head.addr[BYTE_OFS_W +: LINE_IDX_W];

  // Upper address bits alias onto the same line; byte offset bits are meaningless here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{head.addr[PADDR_W-1:BYTE_OFS_W+LINE_IDX_W],
                              head.addr[BYTE_OFS_W-1:0]};

  assign l2_req.ready    = !full;
  assign l2_resp.valid   = (state_q == RESP);
  assign l2_resp.payload = resp_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= l2_req.payload;
  end

  // Backing store is deliberately outside reset so contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < DCACHE_DATA_B_W; b++) begin
        if (head.byte_en[b]) mem_q[head_idx][b*8 +: 8] <= head.data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    wr_en      = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.cmd == M_XWR) begin
            wr_en = 1'b1;
          end else if (head.cmd == M_XRD) begin
            rd_capture = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (l2_resp.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_capture) begin
        resp_q.tag  <= head.tag;
        resp_q.data <= mem_q[head_idx];
      end
    end
  end

endmodule
